// File: rtl/linear_diffusion_layer.sv
// Ascon p_L linear diffusion layer: combinational result plus a 1-cycle registered copy with valid.
// Optional redundant p_L with sticky mismatch flag when ASCON_LDL_ERRDET_EN is defined.
package ascon_pkg;
  typedef logic [4:0][63:0] ascon_state_t;
endpackage

module linear_diffusion_layer
  import ascon_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         valid_i,
  input  ascon_state_t state_array_i,
  output ascon_state_t state_array_o,
  output ascon_state_t state_q_o,
  output logic         valid_o,
  output logic         err_o
);

  localparam int unsigned ROT_A [5] = '{19, 61, 1, 10, 7};
  localparam int unsigned ROT_B [5] = '{28, 39, 6, 17, 41};

  function automatic logic [63:0] ror(input logic [63:0] w, input int unsigned n);
    return (w >> n) | (w << (64 - n));
  endfunction

  ascon_state_t pl_state;
  ascon_state_t state_q;
  logic         valid_q;

  always_comb begin
    pl_state = '0;
    for (int unsigned i = 0; i < 5; i++) begin
      pl_state[i] = state_array_i[i] ^ ror(state_array_i[i], ROT_A[i])
                                     ^ ror(state_array_i[i], ROT_B[i]);
    end
  end

  assign state_array_o = pl_state;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_i;
      if (valid_i) state_q <= pl_state;
    end
  end

  assign state_q_o = state_q;
  assign valid_o   = valid_q;

`ifdef ASCON_LDL_ERRDET_EN
  // Rotates written as slice concatenations so this copy shares no structure with pl_state.
  (* keep = "true", dont_touch = "true" *) ascon_state_t red_state;
  logic err_q;

  always_comb begin
    red_state    = '0;
    red_state[0] = state_array_i[0] ^ {state_array_i[0][18:0], state_array_i[0][63:19]}
                                     ^ {state_array_i[0][27:0], state_array_i[0][63:28]};
    red_state[1] = state_array_i[1] ^ {state_array_i[1][60:0], state_array_i[1][63:61]}
                                     ^ {state_array_i[1][38:0], state_array_i[1][63:39]};
    red_state[2] = state_array_i[2] ^ {state_array_i[2][0],    state_array_i[2][63:1]}
                                     ^ {state_array_i[2][5:0],  state_array_i[2][63:6]};
    red_state[3] = state_array_i[3] ^ {state_array_i[3][9:0],  state_array_i[3][63:10]}
                                     ^ {state_array_i[3][16:0], state_array_i[3][63:17]};
    red_state[4] = state_array_i[4] ^ {state_array_i[4][6:0],  state_array_i[4][63:7]}
                                     ^ {state_array_i[4][40:0], state_array_i[4][63:41]};
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else if (valid_i && (red_state != pl_state)) begin
      err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_linear_diffusion_layer.sv
// Self-checking bench for linear_diffusion_layer: directed vectors, random states against a
// bit-level reference model, pipeline/reset sequences, and the ASCON_LDL_ERRDET_EN error path.
module tb_linear_diffusion_layer;

  logic         clk = 1'b0;
  logic         rst_ni;
  logic         valid_i;
  logic [319:0] state_array_i;
  logic [319:0] state_array_o;
  logic [319:0] state_q_o;
  logic         valid_o;
  logic         err_o;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  linear_diffusion_layer dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .valid_i       (valid_i),
    .state_array_i (state_array_i),
    .state_array_o (state_array_o),
    .state_q_o     (state_q_o),
    .valid_o       (valid_o),
    .err_o         (err_o)
  );

  // Reference: out[k] = x[k] ^ x[(k+a)%64] ^ x[(k+b)%64] per word, straight from the ROR definition.
  function automatic logic [319:0] ref_pl(input logic [319:0] s);
    int unsigned ra [5] = '{19, 61, 1, 10, 7};
    int unsigned rb [5] = '{28, 39, 6, 17, 41};
    logic [319:0] r;
    r = '0;
    for (int w = 0; w < 5; w++)
      for (int k = 0; k < 64; k++)
        r[64*w + k] = s[64*w + k] ^ s[64*w + ((k + ra[w]) % 64)] ^ s[64*w + ((k + rb[w]) % 64)];
    return r;
  endfunction

  function automatic logic [319:0] rand_state();
    logic [319:0] r;
    for (int i = 0; i < 10; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    string        name;
    logic [319:0] stim;
    logic [319:0] exp;
  } vec_t;

  vec_t vecs [5];

  initial begin
    logic [319:0] a, b, c;

    vecs[0] = '{"zero",    320'd0, 320'd0};
    vecs[1] = '{"ones",    {320{1'b1}}, {320{1'b1}}};
    vecs[2] = '{"x0_bit0", 320'd1, {256'd0, 64'h0000_2010_0000_0001}};
    vecs[3] = '{"x2_bit0", 320'd1 << 128, {128'd0, 64'h8400_0000_0000_0001, 128'd0}};
    vecs[4] = '{"x4_bit0", 320'd1 << 256, {64'h0200_0000_0080_0001, 256'd0}};

    rst_ni = 1'b0;
    valid_i = 1'b0;
    state_array_i = '0;
    tick();
    tick();
    chk("reset_q", state_q_o, '0);
    chk("reset_valid", {319'd0, valid_o}, '0);
    chk("reset_err", {319'd0, err_o}, '0);

    // Combinational path is usable while reset is still asserted.
    for (int i = 0; i < 5; i++) begin
      state_array_i = vecs[i].stim;
      #1;
      chk(vecs[i].name, state_array_o, vecs[i].exp);
      chk({vecs[i].name, "_model"}, ref_pl(vecs[i].stim), vecs[i].exp);
    end

    rst_ni = 1'b1;
    valid_i = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      a = rand_state();
      state_array_i = a;
      #1;
      chk("rand_comb", state_array_o, ref_pl(a));
      tick();
      chk("rand_q", state_q_o, ref_pl(a));
      chk("rand_valid", {319'd0, valid_o}, 320'd1);
      chk("rand_err", {319'd0, err_o}, '0);
    end

    // Back-to-back A, B then idle.
    a = rand_state();
    b = rand_state();
    valid_i = 1'b1;
    state_array_i = a;
    tick();
    chk("pipe_valid_a", {319'd0, valid_o}, 320'd1);
    chk("pipe_q_a", state_q_o, ref_pl(a));
    state_array_i = b;
    tick();
    chk("pipe_valid_b", {319'd0, valid_o}, 320'd1);
    chk("pipe_q_b", state_q_o, ref_pl(b));
    valid_i = 1'b0;
    state_array_i = rand_state();
    tick();
    chk("pipe_idle_valid", {319'd0, valid_o}, '0);
    chk("pipe_hold_q", state_q_o, ref_pl(b));
    state_array_i = rand_state();
    tick();
    chk("pipe_hold_valid2", {319'd0, valid_o}, '0);
    chk("pipe_hold_q2", state_q_o, ref_pl(b));

    // Reset wins over valid_i on the same edge.
    c = rand_state();
    valid_i = 1'b1;
    state_array_i = c;
    rst_ni = 1'b0;
    tick();
    chk("rst_mid_q", state_q_o, '0);
    chk("rst_mid_valid", {319'd0, valid_o}, '0);
    chk("rst_mid_err", {319'd0, err_o}, '0);
    chk("rst_mid_comb", state_array_o, ref_pl(c));
    rst_ni = 1'b1;
    tick();
    chk("post_rst_q", state_q_o, ref_pl(c));
    chk("post_rst_valid", {319'd0, valid_o}, 320'd1);

`ifdef ASCON_LDL_ERRDET_EN
    a = rand_state();
    state_array_i = a;
    valid_i = 1'b1;
    #1;
    force dut.red_state = ~ref_pl(a);
    tick();
    chk("errdet_set", {319'd0, err_o}, 320'd1);
    release dut.red_state;
    state_array_i = rand_state();
    tick();
    chk("errdet_sticky", {319'd0, err_o}, 320'd1);
    valid_i = 1'b0;
    tick();
    chk("errdet_sticky_idle", {319'd0, err_o}, 320'd1);
    rst_ni = 1'b0;
    tick();
    chk("errdet_cleared", {319'd0, err_o}, '0);
    rst_ni = 1'b1;
    valid_i = 1'b1;
    tick();
    chk("errdet_stays_clear", {319'd0, err_o}, '0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
